irq_ctrl: RTL and testbench

Parametrised interrupt controller that replaces the single registered irq/irq_addr pair in the MCU top. It collects NCH interrupt sources, each with per-channel enable and edge/level mode, and arbitrates them by fixed priority (lowest index wins). It presents one request and a vector address to the CPU core, and retires the request on an acknowledge. Software configures and inspects it through the CPU I/O register bus.

---
 rtl/irq_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_irq_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
// irq_ctrl: fixed-priority interrupt controller with per-channel enable and
// edge/level mode. It presents one request plus a vector address to the CPU
// and exposes four I/O registers: IEN, IPEND, IMODE and ICUR.
module irq_ctrl #(
  parameter int          NCH      = 8,
  parameter int          SYNC     = 1,
  parameter logic [7:0]  IO_BASE  = 8'h38,
  parameter logic [15:0] VEC_BASE = 16'h0002,
  parameter logic [15:0] VEC_STEP = 16'h0002
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [NCH-1:0]  irq_in,
  input  logic [7:0]      io_addr,
  input  logic            io_re,
  input  logic            io_we,
  input  logic [7:0]      io_wdata,
  output logic [7:0]      io_rdata,
  output logic            irq,
  output logic [15:0]     irq_addr,
  input  logic            irq_ack
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  localparam logic [7:0] A_IEN   = IO_BASE;
  localparam logic [7:0] A_IPEND = IO_BASE + 8'd1;
  localparam logic [7:0] A_IMODE = IO_BASE + 8'd2;
  localparam logic [7:0] A_ICUR  = IO_BASE + 8'd3;

  // Zero-extend a channel vector to the 8-bit register width.
  function automatic logic [7:0] ext8(input logic [NCH-1:0] x);
    logic [7:0] r;
    r = 8'd0;
    r[NCH-1:0] = x;
    return r;
  endfunction

  logic [NCH-1:0] s_r;
  logic [NCH-1:0] p_r;
  logic [NCH-1:0] ien_r;
  logic [NCH-1:0] imode_r;
  logic [NCH-1:0] pend_r;
  logic [1:0]     state_r;
  logic [2:0]     cur_r;
  logic           irq_r;
  logic [15:0]    irq_addr_r;

  logic [NCH-1:0] req_s;
  logic [7:0]     req8_s;
  logic [NCH-1:0] clr_s;
  logic [NCH-1:0] pend_nx_s;
  logic [7:0]     ack8_s;
  logic [2:0]     win_s;
  logic [15:0]    vec_s;
  logic [7:0]     rdata_s;

  // Bring the asynchronous sources into the clock domain.
  if (SYNC != 0) begin : g_sync2
    logic [NCH-1:0] meta_r;
    // Two-stage synchroniser.
    always_ff @(posedge clock) begin
      if (!reset) begin
        meta_r <= {NCH{1'b0}};
        s_r    <= {NCH{1'b0}};
      end else begin
        meta_r <= irq_in;
        s_r    <= meta_r;
      end
    end
  end else begin : g_sync1
    // Single sampling flop.
    always_ff @(posedge clock) begin
      if (!reset) begin
        s_r <= {NCH{1'b0}};
      end else begin
        s_r <= irq_in;
      end
    end
  end

  // Previous synchronised value, used for rising-edge detection.
  always_ff @(posedge clock) begin
    if (!reset) begin
      p_r <= {NCH{1'b0}};
    end else begin
      p_r <= s_r;
    end
  end

  // Pending update: edge channels latch rising edges (set beats clear), level channels follow s.
  always_comb begin
    ack8_s = 8'd1 << cur_r;
    clr_s  = {NCH{1'b0}};
    if (io_we && (io_addr == A_IPEND)) begin
      clr_s = clr_s | io_wdata[NCH-1:0];
    end else begin
      clr_s = clr_s;
    end
    if ((state_r == ST_REQ) && irq_ack) begin
      clr_s = clr_s | ack8_s[NCH-1:0];
    end else begin
      clr_s = clr_s;
    end
    pend_nx_s = (imode_r & ((pend_r & ~clr_s) | (s_r & ~p_r))) | (~imode_r & s_r);
  end

  // Configuration registers and the pending register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      ien_r   <= {NCH{1'b0}};
      imode_r <= {NCH{1'b0}};
      pend_r  <= {NCH{1'b0}};
    end else begin
      pend_r <= pend_nx_s;
      if (io_we && (io_addr == A_IEN)) begin
        ien_r <= io_wdata[NCH-1:0];
      end else begin
        ien_r <= ien_r;
      end
      if (io_we && (io_addr == A_IMODE)) begin
        imode_r <= io_wdata[NCH-1:0];
      end else begin
        imode_r <= imode_r;
      end
    end
  end

  // Request vector, lowest-index winner and its vector address.
  always_comb begin
    req_s  = pend_r & ien_r;
    req8_s = ext8(req_s);
    win_s  = 3'd0;
    for (int i = NCH - 1; i >= 0; i--) begin
      win_s = req_s[i] ? 3'(i) : win_s;
    end
    vec_s = VEC_BASE + ({13'd0, win_s} * VEC_STEP);
  end

  // Request FSM: raise, hold without pre-emption, retire on ack or withdraw.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      irq_r      <= 1'b0;
      irq_addr_r <= 16'd0;
      cur_r      <= 3'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_s != {NCH{1'b0}}) begin
            state_r    <= ST_REQ;
            irq_r      <= 1'b1;
            irq_addr_r <= vec_s;
            cur_r      <= win_s;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_REQ: begin
          if (irq_ack) begin
            irq_r   <= 1'b0;
            state_r <= ST_GAP;
          end else if (!req8_s[cur_r]) begin
            irq_r   <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_REQ;
          end
        end
        ST_GAP: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          irq_r   <= 1'b0;
        end
      endcase
    end
  end

  // Combinational register read mux; zero outside the window or when not reading.
  always_comb begin
    rdata_s = 8'd0;
    if (io_re) begin
      case (io_addr)
        A_IEN:   rdata_s = ext8(ien_r);
        A_IPEND: rdata_s = ext8(pend_r);
        A_IMODE: rdata_s = ext8(imode_r);
        A_ICUR:  rdata_s = {irq_r, 4'd0, cur_r};
        default: rdata_s = 8'd0;
      endcase
    end else begin
      rdata_s = 8'd0;
    end
  end

  assign io_rdata = rdata_s;
  assign irq      = irq_r;
  assign irq_addr = irq_addr_r;

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl (NCH=8, SYNC=1, default map and vectors).
module tb_irq_ctrl;

  localparam logic [7:0] A_IEN   = 8'h38;
  localparam logic [7:0] A_IPEND = 8'h39;
  localparam logic [7:0] A_IMODE = 8'h3A;
  localparam logic [7:0] A_ICUR  = 8'h3B;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  irq_in = 8'h00;
  logic [7:0]  io_addr = 8'h00;
  logic        io_re = 1'b0;
  logic        io_we = 1'b0;
  logic [7:0]  io_wdata = 8'h00;
  logic [7:0]  io_rdata;
  logic        irq;
  logic [15:0] irq_addr;
  logic        irq_ack = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];
  logic        irq_q = 1'b0;

  typedef struct {
    logic [7:0] addr;
    logic       re;
    logic [7:0] exp;
  } rd_vec_t;

  irq_ctrl dut (
    .clock    (clock),
    .reset    (reset),
    .irq_in   (irq_in),
    .io_addr  (io_addr),
    .io_re    (io_re),
    .io_we    (io_we),
    .io_wdata (io_wdata),
    .io_rdata (io_rdata),
    .irq      (irq),
    .irq_addr (irq_addr),
    .irq_ack  (irq_ack)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] exp, input string name);
    io_addr = a;
    io_re   = 1'b1;
    #1;
    check(name, {8'h00, io_rdata}, {8'h00, exp});
    io_re   = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    io_addr  = a;
    io_wdata = d;
    io_we    = 1'b1;
    cyc(1);
    io_we    = 1'b0;
  endtask

  // Scoreboard: every rising irq must match the next expected vector.
  always @(negedge clock) begin
    if (irq && !irq_q) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_req: got irq_addr %h expected no request", irq_addr);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (irq_addr !== e) begin
          n_err++;
          $display("FAIL sb_vector: got %h expected %h", irq_addr, e);
        end
      end
    end
    irq_q = irq;
  end

  initial begin
    rd_vec_t tbl[10];
    tbl[0] = '{A_IEN,   1'b1, 8'h5A};
    tbl[1] = '{A_IPEND, 1'b1, 8'h00};
    tbl[2] = '{A_IMODE, 1'b1, 8'hC3};
    tbl[3] = '{A_ICUR,  1'b1, 8'h06};
    tbl[4] = '{8'h3C,   1'b1, 8'h00};
    tbl[5] = '{8'h37,   1'b1, 8'h00};
    tbl[6] = '{A_IEN,   1'b0, 8'h00};
    tbl[7] = '{A_IMODE, 1'b0, 8'h00};
    tbl[8] = '{8'hFF,   1'b1, 8'h00};
    tbl[9] = '{8'h00,   1'b1, 8'h00};

    // Reset with all sources high.
    reset  = 1'b0;
    irq_in = 8'hFF;
    cyc(2);
    check("rst_irq", {15'd0, irq}, 16'd0);
    check("rst_addr", irq_addr, 16'h0000);
    rd(A_IEN,   8'h00, "rst_ien");
    rd(A_IPEND, 8'h00, "rst_ipend");
    rd(A_IMODE, 8'h00, "rst_imode");
    rd(A_ICUR,  8'h00, "rst_icur");
    reset = 1'b1;
    cyc(1);
    rd(A_IPEND, 8'h00, "rel_ipend");
    irq_in = 8'h00;
    cyc(5);
    check("rel_irq", {15'd0, irq}, 16'd0);

    // Edge channel 3, one-cycle pulse, latency k+3.
    wr(A_IEN, 8'h08);
    wr(A_IMODE, 8'h08);
    exp_q.push_back(16'h0008);
    irq_in = 8'h08;
    cyc(1);
    irq_in = 8'h00;
    cyc(2);
    check("edge_early", {15'd0, irq}, 16'd0);
    cyc(1);
    check("edge_irq", {15'd0, irq}, 16'd1);
    check("edge_addr", irq_addr, 16'h0008);
    rd(A_IPEND, 8'h08, "edge_pend");
    irq_ack = 1'b1;
    cyc(1);
    irq_ack = 1'b0;
    check("edge_ack_low", {15'd0, irq}, 16'd0);
    rd(A_IPEND, 8'h00, "edge_ack_pend");
    cyc(4);
    check("edge_no_rereq", {15'd0, irq}, 16'd0);

    // Priority: channels 5 and 2 together.
    wr(A_IEN, 8'hFF);
    wr(A_IMODE, 8'hFF);
    exp_q.push_back(16'h0006);
    exp_q.push_back(16'h000C);
    irq_in = 8'h24;
    cyc(4);
    check("prio_first", irq_addr, 16'h0006);
    irq_ack = 1'b1;
    cyc(1);
    irq_ack = 1'b0;
    check("prio_gap", {15'd0, irq}, 16'd0);
    cyc(1);
    check("prio_idle", {15'd0, irq}, 16'd0);
    cyc(1);
    check("prio_second_irq", {15'd0, irq}, 16'd1);
    check("prio_second", irq_addr, 16'h000C);
    irq_ack = 1'b1;
    cyc(1);
    irq_ack = 1'b0;
    irq_in  = 8'h00;
    cyc(4);
    check("prio_done", {15'd0, irq}, 16'd0);

    // Level channel 0: ack, gap, re-request; dropping the source withdraws.
    wr(A_IMODE, 8'h00);
    wr(A_IEN, 8'h01);
    exp_q.push_back(16'h0002);
    exp_q.push_back(16'h0002);
    irq_in = 8'h01;
    cyc(4);
    check("lvl_irq", {15'd0, irq}, 16'd1);
    check("lvl_addr", irq_addr, 16'h0002);
    irq_ack = 1'b1;
    cyc(1);
    irq_ack = 1'b0;
    check("lvl_gap", {15'd0, irq}, 16'd0);
    rd(A_IPEND, 8'h01, "lvl_pend_kept");
    cyc(2);
    check("lvl_rereq", {15'd0, irq}, 16'd1);
    irq_in = 8'h00;
    cyc(6);
    check("lvl_drop", {15'd0, irq}, 16'd0);
    cyc(4);

    // Withdraw by W1C of channel 4 while requesting.
    wr(A_IMODE, 8'hFF);
    wr(A_IEN, 8'hFF);
    exp_q.push_back(16'h000A);
    irq_in = 8'h10;
    cyc(4);
    check("wd_irq", {15'd0, irq}, 16'd1);
    irq_in = 8'h00;
    wr(A_IPEND, 8'h10);
    cyc(1);
    check("wd_low", {15'd0, irq}, 16'd0);
    rd(A_ICUR, 8'h04, "wd_icur");
    cyc(3);
    check("wd_idle", {15'd0, irq}, 16'd0);

    // W1C on the same cycle as a new edge: set wins.
    wr(A_IEN, 8'h00);
    irq_in = 8'h02;
    cyc(3);
    rd(A_IPEND, 8'h02, "w1c_pend_set");
    irq_in = 8'h00;
    cyc(3);
    wr(A_IPEND, 8'h02);
    rd(A_IPEND, 8'h00, "w1c_clear");
    irq_in = 8'h02;
    cyc(2);
    wr(A_IPEND, 8'h02);
    rd(A_IPEND, 8'h02, "w1c_set_wins");
    wr(A_IPEND, 8'h02);
    rd(A_IPEND, 8'h00, "w1c_after");

    // ICUR during a channel-6 request.
    wr(A_IEN, 8'h40);
    exp_q.push_back(16'h000E);
    irq_in = 8'h40;
    cyc(4);
    rd(A_ICUR, 8'h86, "icur_ch6");
    irq_ack = 1'b1;
    cyc(1);
    irq_ack = 1'b0;
    irq_in  = 8'h00;
    cyc(4);

    // Register decode table; ICUR ignores writes.
    wr(A_IEN, 8'h5A);
    wr(A_IMODE, 8'hC3);
    wr(A_ICUR, 8'hFF);
    for (int i = 0; i < 10; i++) begin
      io_addr = tbl[i].addr;
      io_re   = tbl[i].re;
      #1;
      check($sformatf("decode_%0d", i), {8'h00, io_rdata}, {8'h00, tbl[i].exp});
      io_re = 1'b0;
    end

    // Reset in the middle of a request drops irq without an ack.
    wr(A_IEN, 8'h01);
    exp_q.push_back(16'h0002);
    irq_in = 8'h01;
    cyc(4);
    check("mid_irq", {15'd0, irq}, 16'd1);
    reset = 1'b0;
    cyc(1);
    check("mid_rst_irq", {15'd0, irq}, 16'd0);
    check("mid_rst_addr", irq_addr, 16'h0000);
    rd(A_IEN, 8'h00, "mid_rst_ien");
    irq_in = 8'h00;
    reset  = 1'b1;
    cyc(5);
    check("mid_after", {15'd0, irq}, 16'd0);

    check("sb_empty", 16'(exp_q.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
